// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-wide RAM port controller: state encoding,
// access-length codes, I/O-region select value and the byte-sequencing helper.
`ifndef Zero
`define Zero 32'h0000_0000
`endif

package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IF_RD  = 2'd1,
    ST_MEM_RD = 2'd2,
    ST_MEM_WR = 2'd3
  } state_t;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;

  localparam logic [1:0] IO_REGION = 2'b11;

  // Wide enough to count edges up to N+1 for a 4-byte read.
  localparam int CNT_W = 3;

  localparam logic [31:0] ZERO_WORD = `Zero;

  // Length code 3 is treated as a word access.
  function automatic logic [CNT_W-1:0] len_to_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   len_to_bytes = CNT_W'(1);
      LEN_H:   len_to_bytes = CNT_W'(2);
      default: len_to_bytes = CNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_engine.sv
// Byte sequencer: drives N address/data beats onto the RAM bus and assembles
// read bytes little-endian; reports the completing edge combinationally.
module mem_byte_engine
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  we,
  input  logic [CNT_W-1:0]      nbytes,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic [7:0]            ram_din,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [7:0]            ram_dout,
  output logic                  ram_wr,
  output logic                  fin,
  output logic [31:0]           rdata_fin
);

  logic                  active_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [CNT_W-1:0]      n_reg;
  logic                  we_reg;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [31:0]           wdata_reg;
  logic [31:0]           acc_reg;

  logic [CNT_W-1:0]      step;
  logic [1:0]            cap_lane;
  logic                  capture;
  logic [31:0]           acc_next;

  // step is the index of the edge being taken, counted from the acceptance edge.
  always_comb begin
    step     = cnt_reg + CNT_W'(1);
    cap_lane = step[1:0] - 2'd2;
    capture  = active_reg && !we_reg && (step >= CNT_W'(2));
    fin      = active_reg && !abort &&
               (we_reg ? (step == n_reg) : (step == n_reg + CNT_W'(1)));
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign acc_next[8*gi +: 8] = (capture && (cap_lane == 2'(gi))) ? ram_din
                                                                     : acc_reg[8*gi +: 8];
    end
  endgenerate

  assign rdata_fin = acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_reg <= 1'b0;
      cnt_reg    <= '0;
      n_reg      <= '0;
      we_reg     <= 1'b0;
      base_reg   <= '0;
      wdata_reg  <= ZERO_WORD;
      acc_reg    <= ZERO_WORD;
      ram_a      <= '0;
      ram_dout   <= 8'h00;
      ram_wr     <= 1'b0;
    end else if (start) begin
      active_reg <= 1'b1;
      cnt_reg    <= '0;
      n_reg      <= nbytes;
      we_reg     <= we;
      base_reg   <= addr;
      wdata_reg  <= wdata;
      acc_reg    <= ZERO_WORD;
      ram_a      <= addr;
      ram_dout   <= wdata[7:0];
      ram_wr     <= we;
    end else if (active_reg) begin
      if (abort) begin
        active_reg <= 1'b0;
        ram_wr     <= 1'b0;
      end else begin
        cnt_reg <= step;
        acc_reg <= acc_next;
        if (step < n_reg) begin
          ram_a    <= base_reg + ADDR_WIDTH'(step);
          ram_dout <= wdata_reg[{step[1:0], 3'b000} +: 8];
        end else begin
          ram_wr <= 1'b0;
        end
        if (fin) active_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Arbiter for the shared byte-wide RAM port: MEM beats IF, IF is cancelled
// by flush, I/O stores wait for io_full to clear; sequencing is delegated.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int IO_SEL_HI  = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [31:0]           if_data,
  output logic                  if_done,
  input  logic                  flush,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_len,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           mem_rdata,
  output logic                  mem_done,
  input  logic                  io_full,
  input  logic [7:0]            ram_din,
  output logic [7:0]            ram_dout,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_wr,
  output logic                  busy
);

  state_t state_reg;

  logic                  is_io;
  logic                  mem_ok;
  logic                  can_arb;
  logic                  start_mem;
  logic                  start_if;
  logic                  eng_start;
  logic                  eng_abort;
  logic                  eng_we;
  logic [CNT_W-1:0]      eng_len;
  logic [ADDR_WIDTH-1:0] eng_addr;
  logic [31:0]           eng_wdata;
  logic                  eng_fin;
  logic [31:0]           eng_rdata;

  // Arbitrating only while both done pulses are low leaves a bubble after each
  // completion, so a request still held from the finished access is not re-served.
  always_comb begin
    is_io     = (mem_addr[IO_SEL_HI:IO_SEL_HI-1] == IO_REGION);
    mem_ok    = mem_req && !(mem_we && is_io && io_full);
    can_arb   = (state_reg == ST_IDLE) && !if_done && !mem_done;
    start_mem = can_arb && mem_ok;
    start_if  = can_arb && !start_mem && if_req && !flush;
    eng_start = start_mem || start_if;
    eng_abort = (state_reg == ST_IF_RD) && flush;
    eng_we    = 1'b0;
    eng_len   = CNT_W'(4);
    eng_addr  = if_addr;
    eng_wdata = ZERO_WORD;
    if (start_mem) begin
      eng_we    = mem_we;
      eng_len   = len_to_bytes(mem_len);
      eng_addr  = mem_addr;
      eng_wdata = mem_wdata;
    end
  end

  mem_byte_engine #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_engine (
    .clk       (clk),
    .rst       (rst),
    .start     (eng_start),
    .abort     (eng_abort),
    .we        (eng_we),
    .nbytes    (eng_len),
    .addr      (eng_addr),
    .wdata     (eng_wdata),
    .ram_din   (ram_din),
    .ram_a     (ram_a),
    .ram_dout  (ram_dout),
    .ram_wr    (ram_wr),
    .fin       (eng_fin),
    .rdata_fin (eng_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      busy      <= 1'b0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_data   <= ZERO_WORD;
      mem_rdata <= ZERO_WORD;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_mem) begin
            state_reg <= mem_we ? ST_MEM_WR : ST_MEM_RD;
            busy      <= 1'b1;
          end else if (start_if) begin
            state_reg <= ST_IF_RD;
            busy      <= 1'b1;
          end
        end
        ST_IF_RD: begin
          // A redirect wins even on the completing edge; the fetched word is dropped.
          if (flush) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end else if (eng_fin) begin
            if_data   <= eng_rdata;
            if_done   <= 1'b1;
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end
        end
        ST_MEM_RD: begin
          if (eng_fin) begin
            mem_rdata <= eng_rdata;
            mem_done  <= 1'b1;
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end
        end
        ST_MEM_WR: begin
          if (eng_fin) begin
            mem_done  <= 1'b1;
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: transaction-level timing model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        flush;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        io_full;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        busy;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_WIDTH(32), .IO_SEL_HI(17)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .io_full(io_full),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .busy(busy)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
  endfunction

  // ---------------- RAM (environment) and reference memory ----------------
  logic [7:0] ram_arr [logic [31:0]];
  logic [7:0] ref_arr [logic [31:0]];

  function automatic logic [7:0] init_byte(logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h3C;
  endfunction
  function automatic logic [7:0] ram_rd(logic [31:0] a);
    return ram_arr.exists(a) ? ram_arr[a] : init_byte(a);
  endfunction
  function automatic logic [7:0] ref_rd(logic [31:0] a);
    return ref_arr.exists(a) ? ref_arr[a] : init_byte(a);
  endfunction
  function automatic void preload(logic [31:0] a, logic [7:0] b);
    ram_arr[a] = b;
    ref_arr[a] = b;
  endfunction

  always @(posedge clk) begin : ram_blk
    logic [7:0] rd;
    rd = ram_rd(ram_a);
    if (ram_wr) ram_arr[ram_a] = ram_dout;
    ram_din <= rd;
  end

  // ---------------- transaction-level reference model ----------------
  bit          m_act = 0;
  bit          m_is_if = 0;
  logic        m_we = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  int          m_n = 0, m_t = 0;

  logic        exp_busy = 0, exp_wr = 0, exp_if_done = 0, exp_mem_done = 0;
  logic        exp_a_valid = 0, exp_dout_valid = 0;
  logic [31:0] exp_a = 0, exp_if_data = 0, exp_mem_rdata = 0;
  logic [7:0]  exp_dout = 0;

  function automatic int len_n(logic [1:0] l);
    return (l == 2'd0) ? 1 : (l == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_word(logic [31:0] a, int n);
    logic [31:0] d = 0;
    for (int k = 0; k < n; k++) d = d | (32'(ref_rd(a + 32'(k))) << (8 * k));
    return d;
  endfunction

  function automatic void model_start(bit is_if, logic we, logic [31:0] a, int n, logic [31:0] wd);
    m_act = 1; m_is_if = is_if; m_we = we; m_addr = a; m_n = n; m_wdata = wd; m_t = 0;
    exp_busy = 1; exp_a = a; exp_a_valid = 1;
    exp_wr = we; exp_dout = wd[7:0]; exp_dout_valid = we;
  endfunction

  // Called at each rising edge with the inputs that were set up before it.
  function automatic void model_step();
    bit prev_done;
    if (exp_wr) ref_arr[exp_a] = exp_dout;
    prev_done = exp_if_done || exp_mem_done;
    exp_if_done = 0;
    exp_mem_done = 0;
    if (rst) begin
      m_act = 0; exp_busy = 0; exp_wr = 0; exp_a = 0; exp_dout = 0;
      exp_a_valid = 1; exp_dout_valid = 1; exp_if_data = 0; exp_mem_rdata = 0;
    end else if (m_act) begin
      m_t++;
      exp_a_valid = 0;
      if (m_is_if && flush) begin
        m_act = 0; exp_wr = 0; exp_busy = 0; exp_dout_valid = 0;
      end else begin
        if (m_t < m_n) begin
          exp_a = m_addr + 32'(m_t);
          exp_a_valid = 1;
          exp_dout = m_wdata[8*m_t +: 8];
        end else begin
          exp_wr = 0;
          exp_dout_valid = 0;
        end
        if (!m_we && m_t == m_n + 1) begin
          if (m_is_if) begin exp_if_data = ref_word(m_addr, m_n); exp_if_done = 1; end
          else begin exp_mem_rdata = ref_word(m_addr, m_n); exp_mem_done = 1; end
          m_act = 0; exp_busy = 0;
        end else if (m_we && m_t == m_n) begin
          exp_mem_done = 1; m_act = 0; exp_busy = 0;
        end
      end
    end else if (!prev_done) begin
      if (mem_req && !(mem_we && mem_addr[17:16] == 2'b11 && io_full))
        model_start(0, mem_we, mem_addr, len_n(mem_len), mem_wdata);
      else if (if_req && !flush)
        model_start(1, 1'b0, if_addr, 4, 32'h0);
    end
  endfunction

  always @(posedge clk) begin
    model_step();
    #1;
    chk("busy", {31'b0, busy}, {31'b0, exp_busy});
    chk("ram_wr", {31'b0, ram_wr}, {31'b0, exp_wr});
    chk("if_done", {31'b0, if_done}, {31'b0, exp_if_done});
    chk("mem_done", {31'b0, mem_done}, {31'b0, exp_mem_done});
    if (exp_a_valid) chk("ram_a", ram_a, exp_a);
    if (exp_dout_valid) chk("ram_dout", {24'b0, ram_dout}, {24'b0, exp_dout});
    if (exp_if_done) chk("if_data", if_data, exp_if_data);
    if (exp_mem_done) chk("mem_rdata", mem_rdata, exp_mem_rdata);
  end

  // ---------------- directed helpers ----------------
  // Counts rising edges from the current negedge until the chosen done pulse.
  task automatic wait_done(input bit use_mem, input int maxc, output int lat,
                           output logic [31:0] d, output int wr_cnt);
    bit found = 0;
    lat = -1; d = 32'hxxxx_xxxx; wr_cnt = 0;
    for (int i = 1; i <= maxc && !found; i++) begin
      @(posedge clk); #2;
      if (ram_wr) wr_cnt++;
      if (use_mem ? mem_done : if_done) begin
        found = 1; lat = i; d = use_mem ? mem_rdata : if_data;
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0000 + 32'($urandom_range(0, 255));
      1:       return 32'h0003_0000 + 32'($urandom_range(0, 15));
      2:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      default: return 32'h0000_1000 + 32'($urandom_range(0, 31));
    endcase
  endfunction

  int          lat, wr_cnt, if_lat, mem_lat, first_wr;
  logic [31:0] d;

  initial begin
    rst = 1; if_req = 0; if_addr = 0; flush = 0; mem_req = 0; mem_we = 0;
    mem_len = 0; mem_addr = 0; mem_wdata = 0; io_full = 0;
    preload(32'h1000, 8'h13); preload(32'h1001, 8'h00);
    preload(32'h1002, 8'h00); preload(32'h1003, 8'h93);
    preload(32'h0020, 8'hAB);
    preload(32'h2000, 8'h6F); preload(32'h2001, 8'h00);
    preload(32'h2002, 8'h40); preload(32'h2003, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_ram_a", ram_a, 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    rst = 0;

    // IF word fetch.
    @(negedge clk); if_req = 1; if_addr = 32'h1000;
    wait_done(0, 20, lat, d, wr_cnt);
    chk("if_word_lat", 32'(lat), 32'd6);
    chk("if_word_data", d, 32'h9300_0013);
    @(negedge clk); if_req = 0;

    // Simultaneous requests: MEM byte load first, then IF after a bubble.
    @(negedge clk);
    mem_req = 1; mem_we = 0; mem_len = 2'd0; mem_addr = 32'h20;
    if_req = 1; if_addr = 32'h1000;
    wait_done(1, 20, lat, d, wr_cnt);
    chk("lb_lat", 32'(lat), 32'd3);
    chk("lb_data", d, 32'h0000_00AB);
    @(negedge clk); mem_req = 0;
    wait_done(0, 20, lat, d, wr_cnt);
    chk("if_after_mem_lat", 32'(lat), 32'd7);
    chk("if_after_mem_data", d, 32'h9300_0013);
    @(negedge clk); if_req = 0;

    // Half store then half load back.
    @(negedge clk);
    mem_req = 1; mem_we = 1; mem_len = 2'd1; mem_addr = 32'h40; mem_wdata = 32'h0000_BEEF;
    wait_done(1, 20, lat, d, wr_cnt);
    chk("sh_lat", 32'(lat), 32'd3);
    chk("sh_wr_cycles", 32'(wr_cnt), 32'd2);
    @(negedge clk); mem_req = 0;
    @(negedge clk); mem_req = 1; mem_we = 0;
    wait_done(1, 20, lat, d, wr_cnt);
    chk("lh_lat", 32'(lat), 32'd4);
    chk("lh_data", d, 32'h0000_BEEF);
    @(negedge clk); mem_req = 0;

    // Flush after E2 of a fetch, then redirect to 0x2000.
    @(negedge clk); if_req = 1; if_addr = 32'h1000;
    repeat (3) @(posedge clk);
    @(negedge clk); flush = 1; if_addr = 32'h2000;
    @(posedge clk); #2;
    chk("flush_busy", {31'b0, busy}, 32'h0);
    chk("flush_wr", {31'b0, ram_wr}, 32'h0);
    chk("flush_if_done", {31'b0, if_done}, 32'h0);
    @(negedge clk); flush = 0;
    wait_done(0, 20, lat, d, wr_cnt);
    chk("redirect_lat", 32'(lat), 32'd6);
    chk("redirect_data", d, 32'h0040_006F);
    @(negedge clk); if_req = 0;

    // I/O byte store held off by io_full while a fetch is served.
    @(negedge clk);
    mem_req = 1; mem_we = 1; mem_len = 2'd0; mem_addr = 32'h0003_0000; mem_wdata = 32'h5A;
    io_full = 1; if_req = 1; if_addr = 32'h1000;
    if_lat = -1; mem_lat = -1; first_wr = -1;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #2;
      if (if_done) if_lat = i;
      if (mem_done) mem_lat = i;
      if (ram_wr && ram_a == 32'h0003_0000 && first_wr < 0) first_wr = i;
      @(negedge clk);
      if (i == 5) io_full = 0;
      if (if_done) if_req = 0;
      if (mem_done) mem_req = 0;
    end
    chk("io_if_lat", 32'(if_lat), 32'd6);
    chk("io_first_wr", 32'(first_wr), 32'd8);
    chk("io_mem_lat", 32'(mem_lat), 32'd9);
    chk("io_ram_byte", {24'b0, ram_rd(32'h0003_0000)}, 32'h5A);

    // Reset during a word store.
    @(negedge clk);
    mem_req = 1; mem_we = 1; mem_len = 2'd2; mem_addr = 32'h50; mem_wdata = 32'h1122_3344;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1;
    @(posedge clk); #2;
    chk("rst_mid_wr", {31'b0, ram_wr}, 32'h0);
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    chk("rst_mid_done", {31'b0, mem_done}, 32'h0);
    @(negedge clk); rst = 0; mem_req = 0;
    repeat (4) @(negedge clk);

    // Random traffic checked every cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (mem_req && mem_done) mem_req = 0;
      else if (!mem_req && $urandom_range(0, 3) == 0) begin
        mem_req = 1; mem_we = 1'($urandom_range(0, 1));
        mem_len = 2'($urandom_range(0, 3)); mem_addr = rand_addr(); mem_wdata = $urandom;
      end
      if (if_req && if_done) if_req = 0;
      else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = rand_addr();
      end
      flush = ($urandom_range(0, 9) == 0);
      if (flush) if_addr = rand_addr();
      io_full = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 0; flush = 0; if_req = 0; mem_req = 0; io_full = 0;
    repeat (20) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
